// File: rtl/mc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// mc_ctrl_unit
// Multi-cycle MIPS control FSM. Each instruction passes through
// FETCH / DECODE / EXEC / MEM / WB. Every datapath strobe is decoded
// combinationally from the current state and the instruction fields.
// The FSM stalls on mem_ready and counts retired instructions.
// Instructions: add, sub, ori, lw, sw, beq, lui, jal, jr and nop.
// An unknown opcode raises illegal in DECODE and the instruction is skipped.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   op, func           IR[31:26] / IR[5:0], valid from DECODE onward
//   zero               ALU equal flag, used by beq in EXEC
//   mem_ready          memory completes the current mem_rd / mem_wr this cycle
//   mem_rd, mem_wr     memory read / write request
//   iord               memory address select: 0 = PC, 1 = ALU result
//   ir_we, pc_we       IR / PC write enables
//   reg_write          register-file write enable
//   pc_src             0 = PC+4, 1 = branch target, 2 = jump target, 3 = GPR[rs]
//   reg_dst            0 = rt, 1 = rd, 2 = $31
//   wb_sel             0 = ALU, 1 = memory data, 2 = imm16<<16, 3 = PC (+4)
//   alu_src_b, ext_op  ALU B operand select / immediate extension mode
//   alu_op             ALU function: add = 0, sub = 1, or = 3
//   state              IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5
//   retire             pulse on the final cycle of each instruction
//   illegal            pulse in DECODE on an unknown opcode
//   retire_cnt         retired instruction count, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module mc_ctrl_unit #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               iord,
    output logic               ir_we,
    output logic               pc_we,
    output logic               reg_write,
    output logic [1:0]         pc_src,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wb_sel,
    output logic               alu_src_b,
    output logic               ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state,
    output logic               retire,
    output logic               illegal,
    output logic [CNT_W-1:0]   retire_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);

    logic [2:0] next_state;

    // Instruction class decode.
    logic is_rtype, is_add, is_sub, is_jr, is_nop;
    logic is_jal, is_beq, is_ori, is_lui, is_lw, is_sw, is_known;

    assign is_rtype = (op == OP_RTYPE);
    assign is_add   = is_rtype && (func == FN_ADD);
    assign is_sub   = is_rtype && (func == FN_SUB);
    assign is_jr    = is_rtype && (func == FN_JR);
    assign is_nop   = is_rtype && !is_add && !is_sub && !is_jr;
    assign is_jal   = (op == OP_JAL);
    assign is_beq   = (op == OP_BEQ);
    assign is_ori   = (op == OP_ORI);
    assign is_lui   = (op == OP_LUI);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_known = is_rtype || is_jal || is_beq || is_ori || is_lui || is_lw || is_sw;

    // ALU controls belonging to the instruction; gated onto the outputs only
    // in the states where the instruction keeps the ALU busy.
    logic [ALUOP_W-1:0] ins_alu_op;
    logic               ins_alu_src_b;
    logic               ins_ext_op;

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path
        // leaves a variable unassigned and no latch is inferred.
        ins_alu_op    = ALU_ADD;
        ins_alu_src_b = 1'b0;
        ins_ext_op    = 1'b0;
        if (is_sub || is_beq) begin
            ins_alu_op = ALU_SUB;
        end else if (is_ori) begin
            ins_alu_op    = ALU_OR;
            ins_alu_src_b = 1'b1;
            ins_ext_op    = 1'b1;
        end else if (is_lw || is_sw) begin
            ins_alu_src_b = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_write  = 1'b0;
        pc_src     = 2'd0;
        reg_dst    = 2'd0;
        wb_sel     = 2'd0;
        alu_src_b  = 1'b0;
        ext_op     = 1'b0;
        alu_op     = ALU_ADD;
        retire     = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_IDLE: next_state = S_FETCH;

            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                if (!is_known) begin
                    illegal    = 1'b1;
                    next_state = S_FETCH;
                end else if (is_jal) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    wb_sel     = 2'd3;
                    pc_we      = 1'b1;
                    pc_src     = 2'd2;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (is_jr) begin
                    pc_we      = 1'b1;
                    pc_src     = 2'd3;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (is_nop) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_op    = ins_alu_op;
                alu_src_b = ins_alu_src_b;
                ext_op    = ins_ext_op;
                if (is_beq) begin
                    // Branch resolves here: the PC is written only when taken.
                    pc_src     = 2'd1;
                    pc_we      = zero;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (is_lw || is_sw) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end

            S_MEM: begin
                // Address and request held steady until memory completes.
                iord      = 1'b1;
                alu_op    = ins_alu_op;
                alu_src_b = ins_alu_src_b;
                ext_op    = ins_ext_op;
                mem_rd    = is_lw;
                mem_wr    = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
                if (is_add || is_sub) begin
                    reg_dst = 2'd1;
                end else if (is_lw) begin
                    wb_sel = 2'd1;
                end else if (is_lui) begin
                    wb_sel = 2'd2;
                end else if (is_ori) begin
                    alu_op    = ins_alu_op;
                    alu_src_b = ins_alu_src_b;
                    ext_op    = ins_ext_op;
                end
            end

            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            retire_cnt <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state <= next_state;
            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_unit
// Self-checking bench for mc_ctrl_unit (CNT_W = 4 so the counter wraps).
// The stimulus process drives op/func/zero/mem_ready one cycle at a time and
// pushes the hand-derived expected output vector for that cycle into a queue.
// The monitor pops one entry on each falling edge and compares it with the
// DUT outputs.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_unit;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic       reg_write;
        logic [1:0] pc_src;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
        logic       alu_src_b;
        logic       ext_op;
        logic [1:0] alu_op;
        logic       retire;
        logic       illegal;
        logic [3:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       mem_rd, mem_wr, iord, ir_we, pc_we, reg_write;
    logic [1:0] pc_src, reg_dst, wb_sel;
    logic       alu_src_b, ext_op;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic       retire, illegal;
    logic [3:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    obs_t  exp_q[$];
    string tag_q[$];
    logic [3:0] cnt_m;

    always #5 clk = ~clk;

    mc_ctrl_unit #(.ALUOP_W(2), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .func       (func),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .reg_write  (reg_write),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .wb_sel     (wb_sel),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .alu_op     (alu_op),
        .state      (state),
        .retire     (retire),
        .illegal    (illegal),
        .retire_cnt (retire_cnt)
    );

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h required %h", name, $time, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t a;
        a = '{state: state, mem_rd: mem_rd, mem_wr: mem_wr, iord: iord,
              ir_we: ir_we, pc_we: pc_we, reg_write: reg_write, pc_src: pc_src,
              reg_dst: reg_dst, wb_sel: wb_sel, alu_src_b: alu_src_b,
              ext_op: ext_op, alu_op: alu_op, retire: retire,
              illegal: illegal, cnt: retire_cnt};
        return a;
    endfunction

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, sample(), e);
        end
    end

    function automatic obs_t mk(input logic [2:0] s);
        obs_t e;
        e       = '0;
        e.state = s;
        return e;
    endfunction

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic step(input obs_t e, input string tag);
        e.cnt = cnt_m;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (e.retire) cnt_m = cnt_m + 4'd1;
    endtask

    task automatic fetch(input int waits);
        obs_t e;
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            e = mk(3'd1); e.mem_rd = 1'b1;
            step(e, "fetch_wait");
        end
        mem_ready = 1'b1;
        e = mk(3'd1); e.mem_rd = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
        step(e, "fetch");
    endtask

    initial begin
        obs_t e;
        // NOTE: stimulus is applied with blocking assignments 1 time unit
        // after the rising edge so the DUT never races the bench.
        rst_n = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
        cnt_m = '0;
        @(posedge clk);
        #1;

        // Reset: all outputs zero, mem_ready has no effect.
        step(mk(3'd0), "reset");
        mem_ready = 1'b1;
        step(mk(3'd0), "reset_ready");
        rst_n = 1'b1;
        step(mk(3'd0), "idle_after_reset");

        // add, zero-wait: FETCH, DECODE, EXEC, WB.
        op = 6'h00; func = 6'h20;
        fetch(0);
        step(mk(3'd2), "add_decode");
        step(mk(3'd3), "add_exec");
        e = mk(3'd5); e.reg_write = 1'b1; e.reg_dst = 2'd1; e.retire = 1'b1;
        step(e, "add_wb");

        // ori with two fetch wait cycles; ALU controls held into WB.
        op = 6'h0D; func = 6'h3F;
        fetch(2);
        step(mk(3'd2), "ori_decode");
        e = mk(3'd3); e.alu_op = 2'd3; e.alu_src_b = 1'b1; e.ext_op = 1'b1;
        step(e, "ori_exec");
        e = mk(3'd5); e.alu_op = 2'd3; e.alu_src_b = 1'b1; e.ext_op = 1'b1;
        e.reg_write = 1'b1; e.retire = 1'b1;
        step(e, "ori_wb");

        // lw with three memory wait cycles; mem_ready low in DECODE/EXEC too.
        op = 6'h23; func = 6'h00;
        fetch(0);
        mem_ready = 1'b0;
        step(mk(3'd2), "lw_decode");
        e = mk(3'd3); e.alu_src_b = 1'b1;
        step(e, "lw_exec");
        for (int i = 0; i < 3; i++) begin
            e = mk(3'd4); e.iord = 1'b1; e.mem_rd = 1'b1; e.alu_src_b = 1'b1;
            step(e, "lw_mem_wait");
        end
        mem_ready = 1'b1;
        e = mk(3'd4); e.iord = 1'b1; e.mem_rd = 1'b1; e.alu_src_b = 1'b1;
        step(e, "lw_mem_done");
        e = mk(3'd5); e.reg_write = 1'b1; e.wb_sel = 2'd1; e.retire = 1'b1;
        step(e, "lw_wb");

        // sw with one memory wait cycle; retires in MEM.
        op = 6'h2B;
        fetch(0);
        step(mk(3'd2), "sw_decode");
        e = mk(3'd3); e.alu_src_b = 1'b1;
        step(e, "sw_exec");
        mem_ready = 1'b0;
        e = mk(3'd4); e.iord = 1'b1; e.mem_wr = 1'b1; e.alu_src_b = 1'b1;
        step(e, "sw_mem_wait");
        mem_ready = 1'b1;
        e.retire = 1'b1;
        step(e, "sw_mem_done");

        // beq taken, then not taken.
        op = 6'h04;
        for (int z = 1; z >= 0; z--) begin
            fetch(0);
            step(mk(3'd2), "beq_decode");
            zero = (z == 1);
            e = mk(3'd3); e.alu_op = 2'd1; e.pc_src = 2'd1;
            e.pc_we = (z == 1); e.retire = 1'b1;
            step(e, (z == 1) ? "beq_taken" : "beq_not_taken");
        end
        zero = 1'b0;

        // lui.
        op = 6'h0F;
        fetch(0);
        step(mk(3'd2), "lui_decode");
        step(mk(3'd3), "lui_exec");
        e = mk(3'd5); e.reg_write = 1'b1; e.wb_sel = 2'd2; e.retire = 1'b1;
        step(e, "lui_wb");

        // jal.
        op = 6'h03;
        fetch(0);
        e = mk(3'd2); e.reg_write = 1'b1; e.reg_dst = 2'd2; e.wb_sel = 2'd3;
        e.pc_we = 1'b1; e.pc_src = 2'd2; e.retire = 1'b1;
        step(e, "jal_decode");

        // jr.
        op = 6'h00; func = 6'h08;
        fetch(0);
        e = mk(3'd2); e.pc_we = 1'b1; e.pc_src = 2'd3; e.retire = 1'b1;
        step(e, "jr_decode");

        // Unknown opcode: illegal pulse, no retire.
        op = 6'h3F; func = 6'h00;
        fetch(0);
        e = mk(3'd2); e.illegal = 1'b1;
        step(e, "illegal_decode");

        // lw interrupted by reset while waiting in MEM.
        op = 6'h23;
        fetch(0);
        step(mk(3'd2), "lw2_decode");
        e = mk(3'd3); e.alu_src_b = 1'b1;
        step(e, "lw2_exec");
        mem_ready = 1'b0;
        e = mk(3'd4); e.iord = 1'b1; e.mem_rd = 1'b1; e.alu_src_b = 1'b1;
        step(e, "lw2_mem_wait");
        rst_n = 1'b0;
        cnt_m = '0;
        step(mk(3'd0), "reset_mid_mem");
        step(mk(3'd0), "reset_hold");
        rst_n = 1'b1;
        step(mk(3'd0), "idle_after_reset2");

        // 17 nops: counter wraps 15 -> 0 and reads 1 afterwards.
        op = 6'h00; func = 6'h00;
        for (int i = 0; i < 17; i++) begin
            fetch(0);
            e = mk(3'd2); e.retire = 1'b1;
            step(e, "nop_decode");
        end
        mem_ready = 1'b0;
        e = mk(3'd1); e.mem_rd = 1'b1;
        step(e, "after_wrap");

        // Let the monitor drain; bounded wait.
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mc_ctrl_unit.md
# mc_ctrl_unit

Multi-cycle MIPS control FSM for the datapath generation after the single-cycle core. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes per state. It stalls on a ready handshake from instruction/data memory and keeps a retired-instruction counter. Supported instructions: add, sub, ori, lw, sw, beq, lui, jal, jr and nop; unknown opcodes are flagged and skipped.

## Interface
- ALUOP_W, 2: alu_op width (≥2); codes zero-extended: add=0, sub=1, or=3
- CNT_W, 32: width of retire counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26], valid from DECODE onward
- func  in  6  IR[5:0], valid from DECODE onward
- zero  in  1  ALU equal flag, valid in EXEC
- mem_ready  in  1  memory completes current mem_rd/mem_wr this cycle
- mem_rd, mem_wr  out  1  memory read / write request
- iord  out  1  address select: 0=PC, 1=ALU result
- ir_we, pc_we, reg_write  out  1  IR / PC / register-file write enables
- pc_src  out  2  0=PC+4, 1=branch target, 2={PC[31:28],imm26,00}, 3=GPR[rs]
- reg_dst  out  2  0=rt, 1=rd, 2=$31
- wb_sel  out  2  0=ALU, 1=mem data, 2=imm16<<16, 3=PC (already +4)
- alu_src_b  out  1  0=GPR[rt], 1=extended imm
- ext_op  out  1  0=sign, 1=zero extend
- alu_op  out  ALUOP_W  ALU function
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5
- retire  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE on unknown opcode
- retire_cnt  out  CNT_W  retired instruction count

## Operation
- Only state and retire_cnt are registered; all other outputs decode combinationally from state, op, func, zero, mem_ready. Outputs not listed for a state are 0.
- IDLE: all strobes 0; → FETCH next cycle.
- FETCH: mem_rd=1, iord=0. On mem_ready: ir_we=1, pc_we=1, pc_src=0, → DECODE; otherwise hold.
- DECODE:
  - jal: reg_write=1, reg_dst=2, wb_sel=3, pc_we=1, pc_src=2, retire, → FETCH.
  - jr (op 0, func 001000): pc_we=1, pc_src=3, retire, → FETCH.
  - nop (op 0, other func): retire, → FETCH.
  - unknown op: illegal=1, no retire, → FETCH.
  - else: → EXEC.
- EXEC: alu_op/alu_src_b/ext_op held for the instruction (add/sub: rt,0/1; ori: imm,zero,3; lw/sw: imm,sign,0; beq: rt,1).
  - beq: pc_src=1, pc_we=zero, retire, → FETCH.
  - add/sub/ori/lui: → WB. lw/sw: → MEM.
- MEM: iord=1, alu controls held; lw: mem_rd=1, sw: mem_wr=1. Hold until mem_ready; then sw: retire, → FETCH; lw: → WB.
- WB: reg_write=1, retire, → FETCH. add/sub: reg_dst=1, wb_sel=0; ori: reg_dst=0, wb_sel=0, alu controls held; lw: reg_dst=0, wb_sel=1; lui: reg_dst=0, wb_sel=2.
- retire_cnt increments by 1 on every retire; it wraps from 2^CNT_W−1 to 0.

## Timing
- Reset (rst_n low, any cycle, mid-instruction included): state=IDLE, retire_cnt=0, every output 0 immediately. The first FETCH is one cycle after rst_n deasserts.
- Zero-wait latency (mem_ready held high), cycles FETCH→retire: jal/jr/nop 2, beq 3, add/sub/ori/lui/sw 4, lw 5. Each memory wait cycle adds 1.
- mem_rd/mem_wr stay asserted and stable, with iord constant, until the cycle mem_ready=1. mem_ready is ignored in states with no request.
- mem_wr and reg_write are never high in the same cycle. pc_we is high at most twice per instruction (FETCH, plus one of DECODE/EXEC).
- Retire and the counter increment in the same cycle; the counter shows the new value on the next cycle.

## Test plan
- Reset mid-MEM of lw (mem_ready low), then release → state 0 and all outputs 0 while reset; FETCH with mem_rd=1 one cycle after release; retire_cnt=0.
- add, mem_ready always 1 → states 1,2,3,5; WB has reg_write=1, reg_dst=1, wb_sel=0, alu_op=0; retire on cycle 4; retire_cnt=1.
- lw with mem_ready low 3 cycles in MEM → mem_rd=1, iord=1 stable for 4 cycles; WB wb_sel=1; retire 8 cycles after FETCH start.
- beq with zero=1, then beq with zero=0 → pc_we=1, pc_src=1 in EXEC only for the first; both retire after 3 cycles.
- jal, then op=6'b111111 → jal: DECODE reg_dst=2, wb_sel=3, pc_src=2, pc_we=1, reg_write=1; unknown op: illegal pulse, no retire, back to FETCH.
- CNT_W=4, 17 nops → retire_cnt wraps 15→0 and reads 1; each nop takes 2 cycles.
